// File: rtl/sync_fifo_ctl.sv
// rtl/sync_fifo_ctl.sv - single-clock FIFO with registered/FWFT read, thresholds, count and sticky errors
module sync_fifo_ctl #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             wovf,
  output logic             rudf
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AF_THR  = AF_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] AE_THR  = AE_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

  if (ASIZE < 1 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
    $error("sync_fifo_ctl: need ASIZE >= 1 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE:0]   wptr_n, rptr_n, count_n;
  logic             wr_acc, rd_acc;

  // Acceptance uses only the registered flags, so a rejected op cannot touch state.
  assign wr_acc = winc && !wfull;
  assign rd_acc = rinc && !rempty;

  always_comb begin
    wptr_n  = wptr;
    rptr_n  = rptr;
    count_n = count;
    if (wr_acc) wptr_n = wptr + PTR_ONE;
    if (rd_acc) rptr_n = rptr + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_n = count + PTR_ONE;
      2'b01:   count_n = count - PTR_ONE;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wovf         <= 1'b0;
      rudf         <= 1'b0;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      count        <= count_n;
      wfull        <= (wptr_n[ASIZE] != rptr_n[ASIZE]) &&
                      (wptr_n[ASIZE-1:0] == rptr_n[ASIZE-1:0]);
      rempty       <= (wptr_n == rptr_n);
      almost_full  <= (count_n >= AF_THR);
      almost_empty <= (count_n <= AE_THR);
      wovf         <= wovf | (winc && wfull);
      rudf         <= rudf | (rinc && rempty);
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is read straight from memory; zero while empty keeps reset/empty output clean.
    assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];
  end else begin : g_reg_read
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (rd_acc) begin
        rdata_q <= mem[rptr[ASIZE-1:0]];
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb/tb_sync_fifo_ctl.sv - scoreboard bench for sync_fifo_ctl in registered and FWFT read modes
module tb_sync_fifo_ctl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wdata, f_wdata;
  logic       winc, rinc, f_winc, f_rinc;
  logic [7:0] rdata, f_rdata;
  logic       wfull, rempty, almost_full, almost_empty, wovf, rudf;
  logic       f_wfull, f_rempty, f_almost_full, f_almost_empty, f_wovf, f_rudf;
  logic [4:0] count, f_count;

  int         errors = 0;
  int         checks = 0;
  int         mcount;
  bit         mwovf, mrudf;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  sync_fifo_ctl #(.DSIZE(8), .ASIZE(4), .FWFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .wovf(wovf), .rudf(rudf)
  );

  sync_fifo_ctl #(.DSIZE(8), .ASIZE(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wdata(f_wdata), .winc(f_winc), .rinc(f_rinc),
    .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .wovf(f_wovf), .rudf(f_rudf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(mcount));
    check("wfull", 32'(wfull), 32'(mcount == DEPTH));
    check("rempty", 32'(rempty), 32'(mcount == 0));
    check("almost_full", 32'(almost_full), 32'(mcount >= DEPTH - 2));
    check("almost_empty", 32'(almost_empty), 32'(mcount <= 2));
    check("wovf", 32'(wovf), 32'(mwovf));
    check("rudf", 32'(rudf), 32'(mrudf));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    winc = 1'b0; rinc = 1'b0; f_winc = 1'b0; f_rinc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mcount = 0; mwovf = 1'b0; mrudf = 1'b0;
    sb.delete();
    check_state();
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_f_rempty", 32'(f_rempty), 32'h1);
    check("reset_f_count", 32'(f_count), 32'h0);
  endtask

  // One clock of stimulus on the registered-read instance; the model predicts acceptance.
  task automatic step(input bit w, input bit r, input logic [7:0] d);
    bit         wa, ra;
    logic [7:0] exp;
    exp = 8'h00;
    winc = w; rinc = r; wdata = d;
    wa = w && (mcount != DEPTH);
    ra = r && (mcount != 0);
    if (w && !wa) mwovf = 1'b1;
    if (r && !ra) mrudf = 1'b1;
    if (ra) exp = sb.pop_front();
    if (wa) sb.push_back(d);
    mcount = mcount + int'(wa) - int'(ra);
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0;
    if (ra) check("rdata", 32'(rdata), 32'(exp));
    check_state();
  endtask

  task automatic f_step(input bit w, input bit r, input logic [7:0] d);
    f_winc = w; f_rinc = r; f_wdata = d;
    @(posedge clk); #1;
    f_winc = 1'b0; f_rinc = 1'b0;
  endtask

  initial begin
    wdata = '0; f_wdata = '0;
    do_reset();

    // Fill and drain with ordered data.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

    // Write+read while full: write rejected, head still returned.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b1, 8'hAA);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00);

    // Write+read while empty: read rejected, word stored.
    step(1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b1, 8'h00);

    // Steady streaming at occupancy 3 across several pointer wraps.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    for (int i = 0; i < 48; i++) step(1'b1, 1'b1, 8'($urandom_range(255)));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

    // Reset with words stored discards them.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    do_reset();
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);

    // FWFT instance.
    f_step(1'b1, 1'b0, 8'h3C);
    check("fwft_rdata_1", 32'(f_rdata), 32'h3C);
    check("fwft_rempty_1", 32'(f_rempty), 32'h0);
    f_step(1'b0, 1'b0, 8'h00);
    check("fwft_rdata_hold", 32'(f_rdata), 32'h3C);
    check("fwft_count_1", 32'(f_count), 32'h1);
    f_step(1'b0, 1'b1, 8'h00);
    check("fwft_rempty_pop", 32'(f_rempty), 32'h1);
    check("fwft_count_0", 32'(f_count), 32'h0);
    f_step(1'b1, 1'b0, 8'hA1);
    f_step(1'b1, 1'b0, 8'hA2);
    check("fwft_head_a1", 32'(f_rdata), 32'hA1);
    f_step(1'b0, 1'b1, 8'h00);
    check("fwft_head_a2", 32'(f_rdata), 32'hA2);
    f_step(1'b0, 1'b1, 8'h00);
    check("fwft_empty_again", 32'(f_rempty), 32'h1);
    f_step(1'b1, 1'b1, 8'h5A);
    check("fwft_udf_count", 32'(f_count), 32'h1);
    check("fwft_rudf", 32'(f_rudf), 32'h1);
    check("fwft_udf_rdata", 32'(f_rdata), 32'h5A);
    check("fwft_wovf", 32'(f_wovf), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
